hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 subset core (R-type, I-type ALU, lw, sw, beq). It sits beside the ID stage and drives the `NoOp_i` bubble input of the ID-stage control decoder, plus the PC / IF-ID write enables and the IF-ID flush. It tracks the EX and MEM stages internally in shadow registers and detects load-use and branch-operand hazards. A data-memory wait FSM freezes the whole pipeline while memory is not ready, with a timeout error.

## Interface
- MEM_TIMEOUT, 16: consecutive not-ready cycles tolerated before the error state; legal range 1..65535.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- Op_i  input  7  opcode of the instruction in ID.
- RS1addr_i  input  5  rs1 of the ID instruction.
- RS2addr_i  input  5  rs2 of the ID instruction.
- RDaddr_i  input  5  rd of the ID instruction.
- BranchTaken_i  input  1  beq in ID resolved taken; only meaningful when Op_i is beq.
- DMemReady_i  input  1  data memory completes the MEM-stage access this cycle.
- NoOp_o  output  1  insert a bubble into ID/EX; feeds the control decoder's `NoOp_i`.
- PCWrite_o  output  1  PC update enable.
- IFIDWrite_o  output  1  IF/ID register write enable.
- Flush_o  output  1  clear IF/ID (taken branch).
- Freeze_o  output  1  hold every pipeline register, including PC.
- MemErr_o  output  1  sticky memory-timeout error.
- StallCnt_o  output  16  saturating count of stall/freeze cycles.

## Operation
- **ID decode (combinational):**
  - Recognised opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BEQ=1100011; any other opcode is treated as a no-op.
  - uses_rs1 = R|I|LW|SW|BEQ; uses_rs2 = R|SW|BEQ.
  - regwrite = R|I|LW; memread = LW; memwrite = SW.
- **Shadow state:** registers EX{rd,regwrite,memread,memwrite} and MEM{same}; reset clears all fields to 0.
- **Match rule:** match(S, r) = S.regwrite & S.rd != 0 & S.rd == r, applied to each used source register.
- **Load-use hazard:** EX.memread & match(EX, used rs).
- **Branch hazard (ID is BEQ):** match(EX, used rs), or MEM.memread & match(MEM, used rs).
- **Stall:** stall = (load-use | branch hazard) & !Freeze_o. On stall: NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0.
- **Flush:** Flush_o = BEQ & BranchTaken_i & !stall & !Freeze_o.
- **Freeze:** Freeze_o = (state==ERR) | (MEM.memread|MEM.memwrite) & !DMemReady_i.
  - While frozen: NoOp_o=0, PCWrite_o=0, IFIDWrite_o=0, Flush_o=0.
- **Priority:** Freeze > stall > flush.
- **Shadow update each edge:**
  - Freeze: hold all shadow state.
  - Otherwise: MEM <= EX, and EX <= bubble (all fields 0) if NoOp_o, else the ID-decoded fields.
- **Memory FSM** (wait_cnt is 16 bits):
  - RUN: if the freeze condition holds, go to WAIT with wait_cnt=1; else stay in RUN.
  - WAIT: if DMemReady_i, go to RUN with wait_cnt=0. Else if wait_cnt==MEM_TIMEOUT, go to ERR. Else wait_cnt+1.
  - ERR: absorbing until rst_i. MemErr_o = (state==ERR). Freeze_o stays 1.
- **StallCnt_o:** +1 on every edge where NoOp_o|Freeze_o; saturates at 16'hFFFF.

## Timing
- **Reset values:** NoOp_o=0, Flush_o=0, Freeze_o=0, MemErr_o=0, StallCnt_o=0, PCWrite_o=1, IFIDWrite_o=1; FSM in RUN; shadow state cleared.
- **Latency:**
  - NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o and Freeze_o are combinational in the same cycle as the ID/MEM condition.
  - MemErr_o is registered.
- **Stall lengths:**
  - Load-use: exactly 1 stall cycle.
  - lw → beq dependency: 2 cycles.
  - ALU → beq dependency: 1 cycle.
- **Timeout:** MemErr_o rises the cycle after the (MEM_TIMEOUT+1)-th consecutive not-ready cycle.
- **Ready during freeze:** DMemReady_i asserted in the same cycle as the freeze condition means no freeze.
- **Simultaneous hazard and taken branch:** stall wins; the flush occurs on the re-evaluated cycle.
- **rst_i mid-stall or in ERR:** full reset on the next edge; no pending stall survives.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants OP_RTYPE, OP_ITYPE, OP_LW, OP_SW, OP_BEQ.
  - Shadow-entry struct {rd, regwrite, memread, memwrite}.
  - FSM state enum {RUN, WAIT, ERR}.
- Sub-module `hazard_decode`: the combinational ID decode of uses_rs1/uses_rs2/regwrite/memread/memwrite. Everything else lives in hazard_ctrl.

## Test plan
- **Reset:** hold rst_i 2 cycles → PCWrite_o=1, IFIDWrite_o=1, all other outputs 0, StallCnt_o=0.
- **Load-use:** lw x5 then add x6,x5,x1 → one cycle of NoOp_o=1, PCWrite_o=0, IFIDWrite_o=0, then the add proceeds; StallCnt_o=1. Same sequence with lw x0 → no stall.
- **Branch operands:** addi x7 then beq x7,x1 → 1 stall cycle; lw x7 then beq x7,x1 → 2 stall cycles.
- **Taken branch:** beq x1,x2 with no hazard and BranchTaken_i=1 → Flush_o=1 for exactly one cycle with NoOp_o=0. Same with a load-use hazard present → stall first, flush the next cycle.
- **Memory wait:** sw in MEM with DMemReady_i=0 for 3 cycles → Freeze_o=1 for 3 cycles, shadow state held, then normal flow; StallCnt_o=3.
- **Timeout:** MEM_TIMEOUT=4, lw in MEM, DMemReady_i stuck at 0 → MemErr_o=1 after the 5th not-ready cycle and stays 1 with Freeze_o=1. Asserting rst_i clears both.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the RV32-subset pipeline control.
//   - Opcode constants for the recognised instruction classes.
//   - shadow_t: the per-stage fields the hazard unit tracks for EX and MEM.
//   - mem_state_e: data-memory wait FSM states.
//   - src_match(): true when a stage will write a nonzero register equal to r.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } shadow_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mem_state_e;

  // x0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic src_match(input shadow_t s, input logic [4:0] r);
    return s.regwrite && (s.rd != 5'd0) && (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// hazard_decode: combinational classification of the instruction in ID.
// Ports:
//   Op_i        in  7  opcode of the ID instruction
//   uses_rs1_o  out 1  instruction reads rs1
//   uses_rs2_o  out 1  instruction reads rs2
//   regwrite_o  out 1  instruction writes rd
//   memread_o   out 1  instruction is a load
//   memwrite_o  out 1  instruction is a store
//   is_beq_o    out 1  instruction is a branch
// Unrecognised opcodes decode to all zeros and behave as a no-op.
module hazard_decode
  import riscv_pkg::*;
(
  input  logic [6:0] Op_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o,
  output logic       regwrite_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       is_beq_o
);

  logic is_r, is_i, is_lw, is_sw, is_beq;

  assign is_r   = (Op_i == OP_RTYPE);
  assign is_i   = (Op_i == OP_ITYPE);
  assign is_lw  = (Op_i == OP_LW);
  assign is_sw  = (Op_i == OP_SW);
  assign is_beq = (Op_i == OP_BEQ);

  assign uses_rs1_o = is_r | is_i | is_lw | is_sw | is_beq;
  assign uses_rs2_o = is_r | is_sw | is_beq;
  assign regwrite_o = is_r | is_i | is_lw;
  assign memread_o  = is_lw;
  assign memwrite_o = is_sw;
  assign is_beq_o   = is_beq;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-operand stall control and data-memory
// wait/freeze for the 5-stage RV32-subset core. Sits beside ID.
// Ports:
//   clk_i          in  1   clock, rising edge
//   rst_i          in  1   synchronous active-high reset
//   Op_i           in  7   ID opcode
//   RS1addr_i      in  5   ID rs1
//   RS2addr_i      in  5   ID rs2
//   RDaddr_i       in  5   ID rd
//   BranchTaken_i  in  1   ID beq resolved taken
//   DMemReady_i    in  1   data memory completes the MEM access this cycle
//   NoOp_o         out 1   bubble into ID/EX
//   PCWrite_o      out 1   PC update enable
//   IFIDWrite_o    out 1   IF/ID write enable
//   Flush_o        out 1   clear IF/ID on taken branch
//   Freeze_o       out 1   hold every pipeline register
//   MemErr_o       out 1   sticky memory-timeout error
//   StallCnt_o     out 16  saturating stall/freeze cycle count
// Parameter MEM_TIMEOUT (1..65535): not-ready cycles tolerated before ERR.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  Op_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        BranchTaken_i,
  input  logic        DMemReady_i,
  output logic        NoOp_o,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        Flush_o,
  output logic        Freeze_o,
  output logic        MemErr_o,
  output logic [15:0] StallCnt_o
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(MEM_TIMEOUT);

  logic uses_rs1, uses_rs2, regwrite, memread, memwrite, is_beq;

  hazard_decode u_decode (
    .Op_i       (Op_i),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2),
    .regwrite_o (regwrite),
    .memread_o  (memread),
    .memwrite_o (memwrite),
    .is_beq_o   (is_beq)
  );

  shadow_t     ex_q, ex_d, mem_q, mem_d, id_entry;
  mem_state_e  state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic ex_hit, mem_hit, load_use, branch_haz, mem_busy, freeze, stall;

  assign id_entry = '{rd: RDaddr_i, regwrite: regwrite, memread: memread, memwrite: memwrite};

  // A used source register matched by a producer in EX or MEM.
  assign ex_hit  = (uses_rs1 & src_match(ex_q,  RS1addr_i)) |
                   (uses_rs2 & src_match(ex_q,  RS2addr_i));
  assign mem_hit = (uses_rs1 & src_match(mem_q, RS1addr_i)) |
                   (uses_rs2 & src_match(mem_q, RS2addr_i));

  // beq resolves in ID, so it needs ALU results one stage earlier than EX
  // would, and load data a further stage on (hence the MEM check).
  assign load_use   = ex_q.memread & ex_hit;
  assign branch_haz = is_beq & (ex_hit | (mem_q.memread & mem_hit));

  // Ready in the same cycle as the access means the access completes: no freeze.
  assign mem_busy = (mem_q.memread | mem_q.memwrite) & ~DMemReady_i;
  assign freeze   = (state_q == ERR) | mem_busy;
  assign stall    = (load_use | branch_haz) & ~freeze;

  assign NoOp_o      = stall;
  assign PCWrite_o   = ~(stall | freeze);
  assign IFIDWrite_o = ~(stall | freeze);
  assign Flush_o     = is_beq & BranchTaken_i & ~stall & ~freeze;
  assign Freeze_o    = freeze;
  assign MemErr_o    = (state_q == ERR);
  assign StallCnt_o  = stall_cnt_q;

  // Shadow pipeline and stall counter next-state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ex_d        = ex_q;
    mem_d       = mem_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      mem_d = ex_q;
      ex_d  = stall ? shadow_t'('0) : id_entry;
    end
    if ((stall | freeze) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Data-memory wait FSM.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d    = WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      WAIT: begin
        if (DMemReady_i) begin
          state_d    = RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TIMEOUT_CNT) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      ex_q        <= '0;
      mem_q       <= '0;
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl. The stimulus side models
// the pipeline as a list of in-flight instructions (opcode, rd) plus a run
// length of consecutive not-ready memory cycles, predicts every output for
// each cycle and queues it; a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  localparam int unsigned T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  Op_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic        BranchTaken_i, DMemReady_i;
  logic        NoOp_o, PCWrite_o, IFIDWrite_o, Flush_o, Freeze_o, MemErr_o;
  logic [15:0] StallCnt_o;

  hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .Op_i          (Op_i),
    .RS1addr_i     (RS1addr_i),
    .RS2addr_i     (RS2addr_i),
    .RDaddr_i      (RDaddr_i),
    .BranchTaken_i (BranchTaken_i),
    .DMemReady_i   (DMemReady_i),
    .NoOp_o        (NoOp_o),
    .PCWrite_o     (PCWrite_o),
    .IFIDWrite_o   (IFIDWrite_o),
    .Flush_o       (Flush_o),
    .Freeze_o      (Freeze_o),
    .MemErr_o      (MemErr_o),
    .StallCnt_o    (StallCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        noop, pcw, ifidw, flush, freeze, memerr;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    logic [4:0] rd;
  } ins_t;

  // Reference model state.
  ins_t ex_m, mem_m;
  int   nr_run;
  bit   err_m;
  int   cnt_m;
  int   nr_left;
  bit   rand_ready;
  obs_t exp_q[$];
  int   vectors, miscompares;

  function automatic bit writes_reg(input logic [6:0] op);
    return op == OP_RTYPE || op == OP_ITYPE || op == OP_LW;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return writes_reg(op) || op == OP_SW || op == OP_BEQ;
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ;
  endfunction

  function automatic bit produces(input ins_t s, input logic [4:0] r);
    return writes_reg(s.op) && s.rd != 5'd0 && s.rd == r;
  endfunction

  // Does the instruction currently in ID need a value that s will produce?
  function automatic bit id_needs(input ins_t s);
    return (reads_rs1(Op_i) && produces(s, RS1addr_i)) ||
           (reads_rs2(Op_i) && produces(s, RS2addr_i));
  endfunction

  function automatic obs_t predict();
    obs_t o;
    bit acc, frz, lu, br, st;
    acc = (mem_m.op == OP_LW) || (mem_m.op == OP_SW);
    frz = err_m || (acc && !DMemReady_i);
    lu  = (ex_m.op == OP_LW) && id_needs(ex_m);
    br  = (Op_i == OP_BEQ) && (id_needs(ex_m) || (mem_m.op == OP_LW && id_needs(mem_m)));
    st  = (lu || br) && !frz;
    o.noop   = st;
    o.pcw    = !(st || frz);
    o.ifidw  = !(st || frz);
    o.flush  = (Op_i == OP_BEQ) && BranchTaken_i && !st && !frz;
    o.freeze = frz;
    o.memerr = err_m;
    o.cnt    = 16'(cnt_m);
    return o;
  endfunction

  task automatic clear_model();
    ex_m   = '{op: 7'h00, rd: 5'h00};
    mem_m  = '{op: 7'h00, rd: 5'h00};
    nr_run = 0;
    err_m  = 1'b0;
    cnt_m  = 0;
  endtask

  // One clock: drive ready, predict, queue, advance the model across the edge.
  task automatic step(output obs_t e);
    bit acc;
    if (nr_left > 0) begin
      DMemReady_i = 1'b0;
      nr_left--;
    end else if (rand_ready) begin
      DMemReady_i = ($urandom_range(0, 3) != 0);
    end else begin
      DMemReady_i = 1'b1;
    end
    e = predict();
    exp_q.push_back(e);
    @(posedge clk_i);
    if (rst_i) begin
      clear_model();
    end else begin
      acc = (mem_m.op == OP_LW) || (mem_m.op == OP_SW);
      if (acc && !DMemReady_i) begin
        nr_run++;
        if (nr_run == int'(T) + 1) err_m = 1'b1;
      end else begin
        nr_run = 0;
      end
      if ((e.noop || e.freeze) && cnt_m < 65535) cnt_m++;
      if (!e.freeze) begin
        mem_m = ex_m;
        ex_m  = e.noop ? '{op: 7'h00, rd: 5'h00} : '{op: Op_i, rd: RDaddr_i};
      end
    end
    #1;
  endtask

  // Present an instruction in ID until the pipeline accepts it (bounded).
  task automatic issue(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic taken);
    obs_t e;
    Op_i = op; RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd; BranchTaken_i = taken;
    for (int i = 0; i < 8; i++) begin
      step(e);
      if (e.pcw) break;
    end
    if (e.flush) begin
      // The flushed fetch arrives in ID as a bubble.
      Op_i = 7'h00; RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0; BranchTaken_i = 1'b0;
      step(e);
    end
  endtask

  task automatic nop();
    issue(7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic apply_reset();
    obs_t e;
    rst_i = 1'b1;
    Op_i = 7'h00; RS1addr_i = '0; RS2addr_i = '0; RDaddr_i = '0; BranchTaken_i = 1'b0;
    DMemReady_i = 1'b1;
    nr_left = 0;
    rand_ready = 1'b0;
    @(posedge clk_i);
    clear_model();
    #1;
    step(e);
    rst_i = 1'b0;
  endtask

  task automatic check(input obs_t e);
    obs_t g;
    g = '{noop: NoOp_o, pcw: PCWrite_o, ifidw: IFIDWrite_o, flush: Flush_o,
          freeze: Freeze_o, memerr: MemErr_o, cnt: StallCnt_o};
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL cycle_outputs t=%0t got noop=%b pcw=%b ifidw=%b flush=%b freeze=%b err=%b cnt=%0d expected noop=%b pcw=%b ifidw=%b flush=%b freeze=%b err=%b cnt=%0d",
               $time, g.noop, g.pcw, g.ifidw, g.flush, g.freeze, g.memerr, g.cnt,
               e.noop, e.pcw, e.ifidw, e.flush, e.freeze, e.memerr, e.cnt);
    end
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() != 0) check(exp_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    ops = '{OP_RTYPE, OP_ITYPE, OP_LW, OP_SW, OP_BEQ, 7'h7F};
    vectors = 0; miscompares = 0;
    clear_model();

    apply_reset();
    nop();

    // Load-use: lw x5; add x6,x5,x1 -> one bubble. Then lw x0 -> none.
    issue(OP_LW, 5'd1, 5'd0, 5'd5, 1'b0);
    issue(OP_RTYPE, 5'd5, 5'd1, 5'd6, 1'b0);
    nop(); nop();
    issue(OP_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    issue(OP_RTYPE, 5'd0, 5'd1, 5'd6, 1'b0);
    nop(); nop();

    // Branch operands: ALU -> beq 1 stall, lw -> beq 2 stalls.
    issue(OP_ITYPE, 5'd1, 5'd0, 5'd7, 1'b0);
    issue(OP_BEQ, 5'd7, 5'd1, 5'd0, 1'b0);
    nop(); nop();
    issue(OP_LW, 5'd1, 5'd0, 5'd7, 1'b0);
    issue(OP_BEQ, 5'd1, 5'd7, 5'd0, 1'b0);
    nop(); nop();

    // Taken branch with no hazard, then with a load hazard (stall, then flush).
    issue(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b1);
    nop(); nop();
    issue(OP_LW, 5'd1, 5'd0, 5'd3, 1'b0);
    issue(OP_BEQ, 5'd3, 5'd1, 5'd0, 1'b1);
    nop(); nop();

    // Memory wait: sw reaches MEM and waits 3 cycles.
    apply_reset();
    issue(OP_SW, 5'd1, 5'd2, 5'd0, 1'b0);
    nop();
    nr_left = 3;
    nop(); nop(); nop();

    // Timeout: lw stuck in MEM; error after the (T+1)-th not-ready cycle.
    apply_reset();
    issue(OP_LW, 5'd1, 5'd0, 5'd4, 1'b0);
    nop();
    nr_left = 1000;
    nop();
    apply_reset();
    nop();

    // Randomised stream over a small register set to provoke dependencies.
    apply_reset();
    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if (err_m) begin
        apply_reset();
        rand_ready = 1'b1;
      end
      issue(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending entries, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
